// File: rtl/game_pkg.sv
// Shared types, codes and helpers for the two-player bell game.
package game_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StDeal  = 3'd1,
        StOpen  = 3'd2,
        StJudge = 3'd3,
        StShow  = 3'd4,
        StOver  = 3'd5
    } state_e;

    localparam logic [1:0] WHO_NONE = 2'b00;
    localparam logic [1:0] WHO_A    = 2'b01;
    localparam logic [1:0] WHO_B    = 2'b10;
    localparam logic [1:0] WHO_DRAW = 2'b11;

    localparam logic [3:0] KEY_A = 4'b0111;
    localparam logic [3:0] KEY_B = 4'b1001;

    localparam int unsigned CARD_CW = 2;
    localparam int unsigned CARD_NW = 3;

    // Adds a 9-bit signed delta to an 8-bit score, clamping to -128..127.
    function automatic logic signed [7:0] sat_add8(input logic signed [7:0] a,
                                                   input logic signed [8:0] b);
        logic signed [9:0] s;
        s = {{2{a[7]}}, a} + {b[8], b};
        if (s > 10'sd127) begin
            return 8'sd127;
        end else if (s < -10'sd128) begin
            return -8'sd128;
        end else begin
            return s[7:0];
        end
    endfunction

endpackage

// File: rtl/bell_judge.sv
// Combinational bell rule: decides whether a card pair makes ringing the bell correct.
module bell_judge
    import game_pkg::*;
(
    input  logic [CARD_CW-1:0] c1_i,
    input  logic [CARD_CW-1:0] c2_i,
    input  logic [CARD_NW-1:0] n1_i,
    input  logic [CARD_NW-1:0] n2_i,
    output logic               bell_o
);

    logic [3:0] sum;

    always_comb begin
        sum = {1'b0, n1_i} + {1'b0, n2_i};
        if (c1_i == c2_i) begin
            bell_o = (sum == 4'd5);
        end else begin
            bell_o = (n1_i == 3'd5) || (n2_i == 3'd5);
        end
    end

endmodule

// File: rtl/bell_round_ctrl.sv
// Round sequencer: deals a card pair, runs the timed bell window, arbitrates buzzes,
// scores the press and decides when the game is over.
module bell_round_ctrl
    import game_pkg::*;
#(
    parameter int unsigned TICK_DIV     = 1000,
    parameter int unsigned WINDOW_TICKS = 200,
    parameter int unsigned WIN_MARGIN   = 10,
    parameter int unsigned MAX_ROUNDS   = 32,
    parameter int unsigned COOLDOWN     = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic                buzz_a_i,
    input  logic                buzz_b_i,
    output logic                deal_req_o,
    input  logic                deal_ack_i,
    input  logic [CARD_CW-1:0]  c1_i,
    input  logic [CARD_CW-1:0]  c2_i,
    input  logic [CARD_NW-1:0]  n1_i,
    input  logic [CARD_NW-1:0]  n2_i,
    output logic signed [7:0]   score_a_o,
    output logic signed [7:0]   score_b_o,
    output logic [5:0]          round_cnt_o,
    output logic [2:0]          phase_o,
    output logic [1:0]          last_who_o,
    output logic                last_right_o,
    output logic [1:0]          winner_o
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned CW = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
    localparam logic [7:0]  WIN_INIT = 8'(WINDOW_TICKS);

    state_e              state_q;
    logic                deal_req_q;
    logic [CARD_CW-1:0]  c1_q, c2_q;
    logic [CARD_NW-1:0]  n1_q, n2_q;
    logic [PW-1:0]       presc_q;
    logic [7:0]          remain_q;
    logic [7:0]          cap_remain_q;
    logic [CW-1:0]       cool_q;
    logic                prio_q;
    logic signed [7:0]   score_a_q, score_b_q;
    logic [5:0]          round_cnt_q;
    logic [1:0]          last_who_q;
    logic                last_right_q;
    logic [1:0]          winner_q;

    logic                bell;
    logic                take_b;
    logic [8:0]          diff;
    logic [8:0]          mag;
    logic                game_done;

    bell_judge u_bell_judge (
        .c1_i   (c1_q),
        .c2_i   (c2_q),
        .n1_i   (n1_q),
        .n2_i   (n2_q),
        .bell_o (bell)
    );

    always_comb begin
        // On a same-cycle double buzz the priority holder takes the round.
        take_b    = buzz_b_i & (~buzz_a_i | prio_q);
        diff      = {score_a_q[7], score_a_q} - {score_b_q[7], score_b_q};
        mag       = diff[8] ? (~diff + 9'd1) : diff;
        game_done = (mag >= 9'(WIN_MARGIN)) || (round_cnt_q == 6'(MAX_ROUNDS));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= StIdle;
            deal_req_q   <= 1'b0;
            c1_q         <= '0;
            c2_q         <= '0;
            n1_q         <= '0;
            n2_q         <= '0;
            presc_q      <= '0;
            remain_q     <= '0;
            cap_remain_q <= '0;
            cool_q       <= '0;
            prio_q       <= 1'b0;
            score_a_q    <= '0;
            score_b_q    <= '0;
            round_cnt_q  <= '0;
            last_who_q   <= WHO_NONE;
            last_right_q <= 1'b0;
            winner_q     <= WHO_NONE;
        end else begin
            case (state_q)
                StIdle, StOver: begin
                    if (start_i) begin
                        score_a_q    <= '0;
                        score_b_q    <= '0;
                        round_cnt_q  <= '0;
                        winner_q     <= WHO_NONE;
                        last_who_q   <= WHO_NONE;
                        last_right_q <= 1'b0;
                        state_q      <= StDeal;
                    end
                end
                StDeal: begin
                    if (deal_ack_i) begin
                        c1_q       <= c1_i;
                        c2_q       <= c2_i;
                        n1_q       <= n1_i;
                        n2_q       <= n2_i;
                        deal_req_q <= 1'b0;
                        remain_q   <= WIN_INIT;
                        presc_q    <= '0;
                        state_q    <= StOpen;
                    end else begin
                        deal_req_q <= 1'b1;
                    end
                end
                StOpen: begin
                    if (buzz_a_i || buzz_b_i) begin
                        last_who_q   <= take_b ? WHO_B : WHO_A;
                        cap_remain_q <= remain_q;
                        if (buzz_a_i && buzz_b_i) begin
                            prio_q <= ~prio_q;
                        end
                        state_q <= StJudge;
                    end else if (presc_q == PW'(TICK_DIV - 1)) begin
                        presc_q  <= '0;
                        remain_q <= remain_q - 8'd1;
                        if (remain_q == 8'd1) begin
                            last_who_q   <= WHO_NONE;
                            last_right_q <= 1'b0;
                            if (round_cnt_q != 6'd63) begin
                                round_cnt_q <= round_cnt_q + 6'd1;
                            end
                            cool_q  <= '0;
                            state_q <= StShow;
                        end
                    end else begin
                        presc_q <= presc_q + PW'(1);
                    end
                end
                StJudge: begin
                    if (bell) begin
                        if (last_who_q == WHO_A) begin
                            score_a_q <= sat_add8(score_a_q, {1'b0, cap_remain_q});
                        end else begin
                            score_b_q <= sat_add8(score_b_q, {1'b0, cap_remain_q});
                        end
                    end else if (last_who_q == WHO_A) begin
                        score_a_q <= sat_add8(score_a_q, -9'sd1);
                        score_b_q <= sat_add8(score_b_q, 9'sd1);
                    end else begin
                        score_b_q <= sat_add8(score_b_q, -9'sd1);
                        score_a_q <= sat_add8(score_a_q, 9'sd1);
                    end
                    last_right_q <= bell;
                    if (round_cnt_q != 6'd63) begin
                        round_cnt_q <= round_cnt_q + 6'd1;
                    end
                    cool_q  <= '0;
                    state_q <= StShow;
                end
                StShow: begin
                    if (cool_q == CW'(COOLDOWN - 1)) begin
                        if (game_done) begin
                            if (score_a_q > score_b_q) begin
                                winner_q <= WHO_A;
                            end else if (score_a_q < score_b_q) begin
                                winner_q <= WHO_B;
                            end else begin
                                winner_q <= WHO_DRAW;
                            end
                            state_q <= StOver;
                        end else begin
                            state_q <= StDeal;
                        end
                    end else begin
                        cool_q <= cool_q + CW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign deal_req_o   = deal_req_q;
    assign score_a_o    = score_a_q;
    assign score_b_o    = score_b_q;
    assign round_cnt_o  = round_cnt_q;
    assign phase_o      = state_q;
    assign last_who_o   = last_who_q;
    assign last_right_o = last_right_q;
    assign winner_o     = winner_q;

endmodule

// File: tb/tb_bell_round_ctrl.sv
// Self-checking bench for bell_round_ctrl: a round model pushes expected results that are
// popped and compared each time the controller enters its result display.
module tb_bell_round_ctrl;

    logic              clk;
    logic              rst;
    logic              start_i;
    logic              buzz_a_i;
    logic              buzz_b_i;
    logic              deal_req_o;
    logic              deal_ack_i;
    logic [1:0]        c1_i, c2_i;
    logic [2:0]        n1_i, n2_i;
    logic signed [7:0] score_a_o, score_b_o;
    logic [5:0]        round_cnt_o;
    logic [2:0]        phase_o;
    logic [1:0]        last_who_o;
    logic              last_right_o;
    logic [1:0]        winner_o;

    bell_round_ctrl #(
        .TICK_DIV     (1),
        .WINDOW_TICKS (8),
        .WIN_MARGIN   (10),
        .MAX_ROUNDS   (32),
        .COOLDOWN     (2)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .buzz_a_i     (buzz_a_i),
        .buzz_b_i     (buzz_b_i),
        .deal_req_o   (deal_req_o),
        .deal_ack_i   (deal_ack_i),
        .c1_i         (c1_i),
        .c2_i         (c2_i),
        .n1_i         (n1_i),
        .n2_i         (n2_i),
        .score_a_o    (score_a_o),
        .score_b_o    (score_b_o),
        .round_cnt_o  (round_cnt_o),
        .phase_o      (phase_o),
        .last_who_o   (last_who_o),
        .last_right_o (last_right_o),
        .winner_o     (winner_o)
    );

    typedef struct {
        int who;
        int right;
        int sa;
        int sb;
        int rnd;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       sb_e;
    int         n_checks = 0;
    int         n_fail   = 0;
    int         ea = 0, eb = 0, ernd = 0;
    bit         prio = 0;
    logic [2:0] prev_phase = 3'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sat8(input int v);
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    function automatic bit tb_bell(input int c1, input int c2, input int n1, input int n2);
        if (c1 == c2) return (n1 + n2) == 5;
        return (n1 == 5) || (n2 == 5);
    endfunction

    // Scoreboard consumer: compares on every entry into the result display.
    always @(negedge clk) begin
        if (rst && phase_o == 3'd4 && prev_phase != 3'd4) begin
            if (sb_q.size() == 0) begin
                check_eq("sb_underflow", sb_q.size(), 1);
            end else begin
                sb_e = sb_q.pop_front();
                check_eq("sb_last_who", int'(last_who_o), sb_e.who);
                check_eq("sb_last_right", int'(last_right_o), sb_e.right);
                check_eq("sb_score_a", int'(score_a_o), sb_e.sa);
                check_eq("sb_score_b", int'(score_b_o), sb_e.sb);
                check_eq("sb_round_cnt", int'(round_cnt_o), sb_e.rnd);
            end
        end
        prev_phase <= phase_o;
    end

    task automatic wait_phase(input logic [2:0] p, input string tag);
        int n = 0;
        while (phase_o != p && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq(tag, int'(phase_o), int'(p));
    endtask

    task automatic wait_deal_req();
        int n = 0;
        while (!deal_req_o && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("deal_req_high", int'(deal_req_o), 1);
    endtask

    task automatic deal(input int c1, input int c2, input int n1, input int n2);
        wait_deal_req();
        deal_ack_i = 1'b1;
        c1_i = 2'(c1);
        c2_i = 2'(c2);
        n1_i = 3'(n1);
        n2_i = 3'(n2);
        @(posedge clk);
        #1;
        deal_ack_i = 1'b0;
        check_eq("open_entry", int'(phase_o), 2);
        check_eq("deal_req_drop", int'(deal_req_o), 0);
    endtask

    // One round: deal, optionally buzz k cycles into the window, model the outcome.
    task automatic play_round(input int c1, input int c2, input int n1, input int n2,
                              input bit a, input bit b, input int k);
        exp_t e;
        int   who;
        bit   bl;
        deal(c1, c2, n1, n2);
        if (a || b) begin
            repeat (k) begin
                @(posedge clk);
                #1;
            end
            buzz_a_i = a;
            buzz_b_i = b;
            bl = tb_bell(c1, c2, n1, n2);
            if (a && b) begin
                who  = prio ? 2 : 1;
                prio = !prio;
            end else begin
                who = a ? 1 : 2;
            end
            if (bl) begin
                if (who == 1) ea = sat8(ea + (8 - k));
                else          eb = sat8(eb + (8 - k));
            end else if (who == 1) begin
                ea = sat8(ea - 1);
                eb = sat8(eb + 1);
            end else begin
                eb = sat8(eb - 1);
                ea = sat8(ea + 1);
            end
            ernd++;
            e = '{who: who, right: int'(bl), sa: ea, sb: eb, rnd: ernd};
            sb_q.push_back(e);
            @(posedge clk);
            #1;
            buzz_a_i = 1'b0;
            buzz_b_i = 1'b0;
            check_eq("judge_entry", int'(phase_o), 3);
        end else begin
            ernd++;
            e = '{who: 0, right: 0, sa: ea, sb: eb, rnd: ernd};
            sb_q.push_back(e);
        end
        wait_phase(3'd4, "show_entry");
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_phase"}, int'(phase_o), 0);
        check_eq({tag, "_deal_req"}, int'(deal_req_o), 0);
        check_eq({tag, "_score_a"}, int'(score_a_o), 0);
        check_eq({tag, "_score_b"}, int'(score_b_o), 0);
        check_eq({tag, "_round"}, int'(round_cnt_o), 0);
        check_eq({tag, "_last_who"}, int'(last_who_o), 0);
        check_eq({tag, "_last_right"}, int'(last_right_o), 0);
        check_eq({tag, "_winner"}, int'(winner_o), 0);
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got 0, expected 1");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        start_i = 1'b0;
        buzz_a_i = 1'b0;
        buzz_b_i = 1'b0;
        deal_ack_i = 1'b0;
        c1_i = '0;
        c2_i = '0;
        n1_i = '0;
        n2_i = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b1;

        pulse_start();
        check_eq("start_to_deal", int'(phase_o), 1);

        play_round(0, 0, 2, 3, 1, 0, 3);   // A right, award 5
        play_round(0, 1, 1, 2, 0, 1, 0);   // B wrong
        play_round(0, 1, 5, 1, 1, 1, 7);   // tie -> A
        play_round(2, 2, 1, 4, 1, 1, 7);   // tie -> B
        play_round(1, 2, 3, 3, 0, 0, 0);   // window expires
        play_round(3, 3, 0, 5, 1, 0, 5);   // A reaches 10 vs 0

        wait_phase(3'd5, "over_entry");
        check_eq("winner_a", int'(winner_o), 1);

        buzz_a_i = 1'b1;
        deal_ack_i = 1'b1;
        @(posedge clk);
        #1;
        buzz_a_i = 1'b0;
        deal_ack_i = 1'b0;
        check_eq("over_hold_phase", int'(phase_o), 5);
        check_eq("over_frozen_a", int'(score_a_o), ea);
        check_eq("over_frozen_b", int'(score_b_o), eb);

        pulse_start();
        ea = 0;
        eb = 0;
        ernd = 0;
        check_eq("restart_phase", int'(phase_o), 1);
        check_eq("restart_score_a", int'(score_a_o), 0);
        check_eq("restart_winner", int'(winner_o), 0);
        check_eq("restart_round", int'(round_cnt_o), 0);

        play_round(1, 2, 5, 0, 1, 0, 0);   // A right, award 8

        deal(0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_all_zero("rst_open");
        rst = 1'b1;

        pulse_start();
        wait_deal_req();
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_all_zero("rst_deal");
        rst = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check_eq("sb_drained", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bell_round_ctrl.md
Name: bell_round_ctrl

Overview:
- Round sequencer for the two-player bell game.
- Each round: requests a card pair from the deck block, then opens a timed bell window. It arbitrates the two players' buzz pulses, judges the card pair, updates both scores and decides game over.
- Sits between the keypad decoder (buzz pulses), the deck/card source (handshake) and the score/LED display.

Parameters:
- TICK_DIV, 1000, clk cycles per window tick (prescaler).
- WINDOW_TICKS, 200, length of the bell window in ticks; also the maximum award.
- WIN_MARGIN, 10, score lead that ends the game.
- MAX_ROUNDS, 32, round count that ends the game.
- COOLDOWN, 16, clk cycles of result display between rounds.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- start  in  1  one-cycle pulse; begins a game from IDLE or OVER
- buzz_a  in  1  one-cycle pulse, player A pressed bell (keypad code 7)
- buzz_b  in  1  one-cycle pulse, player B pressed bell (keypad code 9)
- deal_req  out  1  request for a new card pair
- deal_ack  in  1  card pair valid on c1/c2/n1/n2 this cycle
- c1, c2  in  2  card colours
- n1, n2  in  3  card numbers
- score_a, score_b  out  8  signed two's-complement scores
- round_cnt  out  6  rounds completed
- phase  out  3  current FSM state encoding
- last_who  out  2  01=A, 10=B, 00=none; buzzer of last round
- last_right  out  1  last judged press was correct
- winner  out  2  01=A, 10=B, 11=draw, 00=game not over

Behaviour:
- Reset (rst=0 at clk edge), applied in any state including mid-round:
  - state IDLE; all outputs 0; card latches, tick counters and priority flag cleared.
  - Priority flag cleared means A has priority.
- States: IDLE, DEAL, OPEN, JUDGE, SHOW, OVER.
- IDLE:
  - start=1 → DEAL.
  - The same clock edge clears the scores, round_cnt, winner, last_who and last_right.
- DEAL:
  - deal_req=1 (registered, asserted the cycle after entry).
  - On deal_ack=1: latch c1/c2/n1/n2, drop deal_req on the next edge, load remain=WINDOW_TICKS and prescaler=0, go to OPEN.
  - deal_req stays high indefinitely until deal_ack.
  - deal_ack outside DEAL is ignored.
- Bell rule (combinational on the latched cards):
  - same colour and n1+n2==5 (4-bit sum), or
  - different colour and (n1==5 or n2==5).
- OPEN:
  - The prescaler counts 0..TICK_DIV-1; remain decrements on wrap.
  - First buzz captured wins; record who plus remain at that cycle → JUDGE.
  - buzz_a and buzz_b in the same cycle: the priority holder wins, then the priority flag toggles.
  - remain reaching 0 with no buzz: last_who=00, last_right=0, no score change → SHOW.
  - Buzzes arriving outside OPEN are ignored.
- JUDGE (exactly 1 cycle):
  - Correct press: presser += captured remain.
  - Wrong press: presser -= 1, opponent += 1.
  - All adds saturate to the range -128..127.
  - Set last_right; increment round_cnt (saturates at 63) → SHOW.
- SHOW: hold for COOLDOWN cycles, then:
  - |score_a - score_b| >= WIN_MARGIN (computed at 9-bit signed), or round_cnt == MAX_ROUNDS → OVER;
  - else → DEAL.
- OVER:
  - winner = higher score; 11 if equal.
  - Scores frozen.
  - start → behaves as from IDLE (new game).
- start is ignored in every state other than IDLE and OVER.
- Latency:
  - buzz to score update: 2 edges (capture in OPEN, update at the JUDGE edge).
  - deal_ack to OPEN: 1 edge.

Decomposition:
- Shared package game_pkg:
  - state encoding;
  - who codes (WHO_NONE/A/B);
  - KEY_A=4'b0111, KEY_B=4'b1001;
  - card field widths;
  - a sat_add8 function.
- One natural sub-module: bell_judge, the combinational bell rule, reusable by the display/debug path.
- Prescaler and window counter stay inline.

Test Plan (TICK_DIV=1, WINDOW_TICKS=8, COOLDOWN=2, WIN_MARGIN=10):
- Reset, start, deal c1=c2=0, n1=2, n2=3; buzz_a 3 cycles after OPEN entry → score_a=5, score_b=0, last_who=01, last_right=1.
- Deal c1=0, c2=1, n1=1, n2=2; buzz_b → score_b=-1 (8'hFF), score_a=+1, last_right=0.
- Same-cycle buzz_a+buzz_b twice on valid pairs → first round won by A, second by B (priority toggle).
- No buzz for 8 ticks → SHOW with last_who=00, scores unchanged, round_cnt+1, deal_req re-asserted after COOLDOWN.
- Drive score_a to 10 vs score_b 0 → OVER after SHOW, winner=01; further buzz ignored; start clears the scores.
- rst=0 during OPEN and during DEAL with deal_req high → next cycle IDLE, deal_req=0, all outputs 0.
